// File: rtl/mac_pkg.sv
// Shared MAC types: stream beat struct, statistics selector and Ethernet length limits.
package mac_pkg;

  localparam int unsigned ETH_MIN_LEN = 64;
  localparam int unsigned ETH_MAX_LEN = 1518;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic       valid;
    logic [7:0] data;
    logic       error;
  } stream_t;

  typedef enum logic [2:0] {
    GOOD     = 3'd0,
    ERR      = 3'd1,
    RUNT     = 3'd2,
    OVERSIZE = 3'd3,
    ABORTED  = 3'd4,
    BYTES    = 3'd5
  } stat_sel_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } rx_state_e;

endpackage

// File: rtl/stat_counter.sv
// Single statistics counter: clear has priority over increment; overflow either
// saturates at all-ones or wraps modulo 2**WIDTH depending on SATURATE.
module stat_counter
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH     = 14,
  parameter int unsigned SATURATE  = 1,
  parameter int unsigned AMT_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 inc,
  input  logic [AMT_WIDTH-1:0] amount,
  output logic [WIDTH-1:0]     count
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum     = {1'b0, count_q} + (WIDTH+1)'(amount);
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      if (sum[WIDTH] && (SATURATE != 0)) count_d = '1;
      else                               count_d = sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/mac_rx_stats.sv
// Receive statistics: classifies frames by length/error and exposes one selected counter.
// Define MAC_RX_STATS_BYTES_EN to build the good-frame byte counter (sel = 5).
module mac_rx_stats
  import mac_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = 14,
  parameter int unsigned BYTE_WIDTH = 32,
  parameter int unsigned MIN_LEN    = ETH_MIN_LEN,
  parameter int unsigned MAX_LEN    = ETH_MAX_LEN,
  parameter int unsigned SATURATE   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_error,
  input  logic                  clear,
  input  logic [2:0]            sel,
  output logic [BYTE_WIDTH-1:0] stat_out,
  output logic                  stat_out_valid,
  output logic                  frame_done
);

  localparam int unsigned      LEN_W   = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_CAP = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  stream_t beat;
  assign beat = '{sop: in_startofpacket, eop: in_endofpacket, valid: in_valid,
                  data: in_data, error: in_error};

  logic unused_data;
  assign unused_data = ^beat.data;

  rx_state_e        state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, len_inc, frame_len;
  logic             classify, inc_good, inc_err, inc_runt, inc_over, inc_abort;

  assign len_inc = (len_q == LEN_CAP) ? LEN_CAP : len_q + ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    unique case (state_q)
      ST_IDLE: begin
        if (beat.valid && beat.sop) begin
          len_d = ONE;
          if (!beat.eop) state_d = ST_IN_FRAME;
        end
      end
      ST_IN_FRAME: begin
        if (beat.valid) begin
          if (beat.eop) begin
            len_d   = len_inc;
            state_d = ST_IDLE;
          end else if (beat.sop) begin
            len_d = ONE;
          end else begin
            len_d = len_inc;
          end
        end
      end
    endcase
  end

  // A single-beat frame in IDLE has length 1; otherwise the eop beat itself adds one.
  always_comb begin
    classify  = 1'b0;
    frame_len = len_inc;
    inc_good  = 1'b0;
    inc_err   = 1'b0;
    inc_runt  = 1'b0;
    inc_over  = 1'b0;
    inc_abort = 1'b0;
    if (beat.valid) begin
      if (state_q == ST_IDLE) begin
        frame_len = ONE;
        classify  = beat.sop && beat.eop;
      end else begin
        classify  = beat.eop;
        inc_abort = beat.sop && !beat.eop;
      end
    end
    if (classify) begin
      if (beat.error)              inc_err  = 1'b1;
      else if (frame_len < MIN_L)  inc_runt = 1'b1;
      else if (frame_len > MAX_L)  inc_over = 1'b1;
      else                         inc_good = 1'b1;
    end
  end

  logic [4:0]           inc_vec;
  logic [CNT_WIDTH-1:0] cnt [5];
  logic [BYTE_WIDTH-1:0] bytes_cnt;

  assign inc_vec = {inc_abort, inc_over, inc_runt, inc_err, inc_good};

  for (genvar g = 0; g < 5; g++) begin : g_cnt
    stat_counter #(
      .WIDTH    (CNT_WIDTH),
      .SATURATE (SATURATE),
      .AMT_WIDTH(1)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .inc   (inc_vec[g]),
      .amount(1'b1),
      .count (cnt[g])
    );
  end

`ifdef MAC_RX_STATS_BYTES_EN
  stat_counter #(
    .WIDTH    (BYTE_WIDTH),
    .SATURATE (SATURATE),
    .AMT_WIDTH(LEN_W)
  ) u_bytes (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (inc_good),
    .amount(frame_len),
    .count (bytes_cnt)
  );
`else
  assign bytes_cnt = '0;
`endif

  logic [BYTE_WIDTH-1:0] stat_q, stat_d;
  logic [2:0]            sel_q;
  logic                  stat_valid_q, stat_valid_d;
  logic                  frame_done_q, frame_done_d;

  always_comb begin
    stat_d = '0;
    case (stat_sel_e'(sel))
      GOOD:     stat_d = BYTE_WIDTH'(cnt[0]);
      ERR:      stat_d = BYTE_WIDTH'(cnt[1]);
      RUNT:     stat_d = BYTE_WIDTH'(cnt[2]);
      OVERSIZE: stat_d = BYTE_WIDTH'(cnt[3]);
      ABORTED:  stat_d = BYTE_WIDTH'(cnt[4]);
      BYTES:    stat_d = bytes_cnt;
      default:  stat_d = '0;
    endcase
    stat_valid_d = (stat_d != stat_q) || (sel != sel_q);
    frame_done_d = classify;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_q       <= '0;
      sel_q        <= '0;
      stat_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      stat_q       <= stat_d;
      sel_q        <= sel;
      stat_valid_q <= stat_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign stat_out       = stat_q;
  assign stat_out_valid = stat_valid_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_mac_rx_stats.sv
// Scoreboard bench for mac_rx_stats: expected stat_out values are queued by the
// stimulus and popped by a monitor on every stat_out_valid strobe.
module tb_mac_rx_stats;
  import mac_pkg::*;

  logic        clk = 1'b0;
  logic        reset, sop, eop, valid, err, clear, clr_small;
  logic [7:0]  data;
  logic [2:0]  sel;
  logic [31:0] stat_out, sat_stat, wrap_stat;
  logic        stat_valid, frame_done;
  logic        sat_unused_v, sat_unused_fd, wrap_unused_v, wrap_unused_fd;

  int unsigned checks = 0, failures = 0, frames_seen = 0, frames_exp = 0;
  logic [31:0] exp_q[$];

  always #4 clk = ~clk;

  mac_rx_stats dut (
    .clk(clk), .reset(reset), .in_startofpacket(sop), .in_endofpacket(eop),
    .in_valid(valid), .in_data(data), .in_error(err), .clear(clear), .sel(sel),
    .stat_out(stat_out), .stat_out_valid(stat_valid), .frame_done(frame_done)
  );

  mac_rx_stats #(.CNT_WIDTH(4), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .in_startofpacket(sop), .in_endofpacket(eop),
    .in_valid(valid), .in_data(data), .in_error(err), .clear(clr_small), .sel(sel),
    .stat_out(sat_stat), .stat_out_valid(sat_unused_v), .frame_done(sat_unused_fd)
  );

  mac_rx_stats #(.CNT_WIDTH(4), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .in_startofpacket(sop), .in_endofpacket(eop),
    .in_valid(valid), .in_data(data), .in_error(err), .clear(clr_small), .sel(sel),
    .stat_out(wrap_stat), .stat_out_valid(wrap_unused_v), .frame_done(wrap_unused_fd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done === 1'b1) frames_seen++;
    if (stat_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got %0d expected no strobe", stat_out);
      end else begin
        check("stat_out", stat_out, exp_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] bexp(input logic [31:0] v);
`ifdef MAC_RX_STATS_BYTES_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  task automatic beat(input logic s, input logic e, input logic er);
    sop = s; eop = e; err = er; valid = 1'b1; data = data + 8'd1;
    @(posedge clk); #1;
    sop = 1'b0; eop = 1'b0; err = 1'b0; valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic er);
    if (n == 1) begin
      beat(1'b1, 1'b1, er);
    end else begin
      beat(1'b1, 1'b0, 1'b0);
      for (int i = 2; i < n; i++) beat(1'b0, 1'b0, 1'b0);
      beat(1'b0, 1'b1, er);
    end
    frames_exp++;
  endtask

  task automatic send_open(input int n);
    beat(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < n; i++) beat(1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [2:0] s, input logic [31:0] e);
    idle(3);
    sel = s;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; sop = 1'b0; eop = 1'b0; valid = 1'b0; err = 1'b0;
    clear = 1'b0; clr_small = 1'b0; data = 8'd0; sel = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stat_out", stat_out, 0);
    check("reset_stat_valid", {31'd0, stat_valid}, 0);
    check("reset_frame_done", {31'd0, frame_done}, 0);
    reset = 1'b0;
    idle(2);

    // 64-byte good frame: counter at N+1, stat_out at N+2
    exp_q.push_back(1);
    send_frame(64, 1'b0);
    check("frame_done_n1", {31'd0, frame_done}, 1);
    check("stat_out_n1_old", stat_out, 0);
    set_sel(3'd5, bexp(64));

    // runt, oversize, single-beat runt
    set_sel(3'd2, 0);
    exp_q.push_back(1);
    send_frame(63, 1'b0);
    send_frame(1519, 1'b0);
    exp_q.push_back(2);
    send_frame(1, 1'b0);
    set_sel(3'd3, 1);
    set_sel(3'd0, 1);

    // error wins over length
    set_sel(3'd1, 0);
    exp_q.push_back(1);
    send_frame(100, 1'b1);
    set_sel(3'd2, 2);

    // abort by sop inside an open frame
    set_sel(3'd4, 0);
    exp_q.push_back(1);
    send_open(29);
    send_frame(70, 1'b0);
    set_sel(3'd0, 2);
    set_sel(3'd5, bexp(134));

    // back-to-back single-beat runts, one per cycle
    set_sel(3'd2, 2);
    exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(5);
    send_frame(1, 1'b0);
    send_frame(1, 1'b0);
    send_frame(1, 1'b0);

    // sop directly after eop, then a single-cycle gap
    set_sel(3'd0, 2);
    exp_q.push_back(3);
    send_frame(64, 1'b0);
    exp_q.push_back(4);
    send_frame(64, 1'b0);
    idle(1);
    exp_q.push_back(5);
    send_frame(64, 1'b0);
    set_sel(3'd5, bexp(326));

    // clear coincident with a good eop: increment lost
    set_sel(3'd0, 5);
    exp_q.push_back(0);
    send_open(63);
    clear = 1'b1;
    beat(1'b0, 1'b1, 1'b0);
    clear = 1'b0;
    frames_exp++;
    set_sel(3'd1, 0);
    set_sel(3'd3, 0);
    set_sel(3'd5, 0);

    // reset mid-frame, then stray beats without sop must be ignored
    set_sel(3'd0, 0);
    send_open(20);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset_mid_stat_out", stat_out, 0);
    for (int i = 0; i < 40; i++) beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    idle(3);
    check("stray_no_frames", frames_seen, frames_exp);
    exp_q.push_back(1);
    send_frame(64, 1'b0);

    // 4-bit counters: saturate vs wrap over 20 good frames
    idle(3);
    clr_small = 1'b1;
    @(posedge clk); #1;
    clr_small = 1'b0;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(32'(i + 2));
      send_frame(64, 1'b0);
    end
    idle(3);
    check("sat4_good", sat_stat, 15);
    check("wrap4_good", wrap_stat, 4);

    idle(5);
    check("queue_drained", exp_q.size(), 0);
    check("frame_count", frames_seen, frames_exp);
    check("frame_count_abs", frames_seen, 34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_rx_stats.md
# mac_rx_stats

Parametrised receive-statistics engine on the MAC clock domain. It consumes the byte stream from the `rgmii` receiver (startofpacket/endofpacket/valid/data/error) and classifies every frame by length and error status. It maintains a bank of saturating or wrapping counters and presents one selected counter, with an update strobe, to `seven_segment_display` or to the LEDs. It replaces the single ad-hoc packet counter in the board top with per-category counts, runtime selection and clear.

## Interface
- `CNT_WIDTH`, 14, width of each frame counter (14 bits covers 9999 for the decimal display)
- `BYTE_WIDTH`, 32, width of the byte counter
- `MIN_LEN`, 64, shortest legal frame in bytes, FCS included
- `MAX_LEN`, 1518, longest legal frame in bytes, FCS included
- `SATURATE`, 1, 1 = counters hold at all-ones; 0 = counters wrap to zero
- `clk` in 1: MAC clock, 125 MHz
- `reset` in 1: asynchronous, active-high reset
- `in_startofpacket` in 1: first beat of frame, qualified by `in_valid`
- `in_endofpacket` in 1: last beat of frame, qualified by `in_valid`
- `in_valid` in 1: beat valid
- `in_data` in 8: frame byte (not inspected; carried only for the ILA)
- `in_error` in 1: FCS/PHY error for the frame, sampled on the endofpacket beat
- `clear` in 1: synchronous zeroing of all counters
- `sel` in 3: counter select, 0 good, 1 err, 2 runt, 3 oversize, 4 aborted, 5 bytes
- `stat_out` out BYTE_WIDTH: selected counter, zero-extended
- `stat_out_valid` out 1: one-cycle strobe, `stat_out` changed or was reselected
- `frame_done` out 1: one-cycle pulse per classified frame

## Operation
- FSM states are IDLE and IN_FRAME. Reset state is IDLE.
- IDLE: a beat with valid & sop loads `len` = 1 and moves to IN_FRAME. If eop is also asserted on that beat, the frame is classified immediately and the FSM stays in IDLE.
- IN_FRAME: each valid beat increments `len`. `len` is `$clog2(MAX_LEN+2)` bits wide and saturates at MAX_LEN+1.
- IN_FRAME, valid & eop: classify the frame and return to IDLE.
- IN_FRAME, valid & sop without eop: increment `aborted`, restart `len` = 1, and stay in IN_FRAME.
- Beats with `in_valid` = 0 are ignored.
- An eop beat seen in IDLE without sop is ignored and not counted.
- Classification priority is first match wins:
  - `in_error` → err
  - `len` < MIN_LEN → runt
  - `len` > MAX_LEN → oversize
  - otherwise → good; the good-frame `len` is also added to `bytes`
- Saturation: with SATURATE=1, a counter at all-ones stays there. With SATURATE=0 it wraps to 0. The byte counter saturates or wraps likewise, so an addition that would overflow yields all-ones (saturate) or the modulo result (wrap).
- `clear` zeroes every counter. Clear beats a simultaneous increment, so that increment is lost. Clear does not affect the FSM or `len`.
- `sel` values 6–7, or 5 when byte counting is compiled out, give `stat_out` = 0.

## Timing
- Every output and every counter resets to 0. FSM resets to IDLE.
- Classification happens at the eop beat (cycle N). The counter is updated and `frame_done` pulses at N+1.
- `stat_out` is registered and reflects a counter at N+2. `stat_out_valid` pulses at N+2 only if the selected counter changed.
- When `sel` changes at cycle M, `stat_out` shows the new counter and `stat_out_valid` pulses at M+1.
- Throughput: back-to-back frames with a single-beat gap, or sop directly after eop, are classified without loss.
- When `reset` asserts mid-frame, the partial frame is discarded and not counted as aborted.

## Configuration
- `MAC_RX_STATS_BYTES_EN`
  - Defined: the BYTE_WIDTH byte counter and its adder are built, and `sel` = 5 is valid.
  - Undefined: no byte counter is built, `sel` = 5 reads 0, and `stat_out` upper bits above CNT_WIDTH are tied 0.

## Structure
- The shared package `mac_pkg` holds:
  - `stream_t`, the packed struct also used by the board top
  - the `stat_sel_e` enum (GOOD=0 … BYTES=5)
  - the `ETH_MIN_LEN` and `ETH_MAX_LEN` constants used as parameter defaults
- Sub-module `stat_counter`: parametrised WIDTH and SATURATE, with inputs clk, reset, clear, inc, and an increment amount. It is instantiated once per category and once for bytes.

## Test plan
- 64-byte frame, error=0, sel=0 → good=1 at N+1, `stat_out`=1 with `stat_out_valid` at N+2, bytes=64.
- 63-byte frame, then a 1519-byte frame, then a 1-beat frame (sop=eop) → runt=2, oversize=1, good=0.
- 100-byte frame with error=1 on eop → err=1, runt unchanged.
- sop at beat 30 of an open frame, then a 70-byte frame completes → aborted=1, good=1, bytes=70.
- SATURATE=1, CNT_WIDTH=4, 20 good frames → good=15. With SATURATE=0 the same stimulus gives good=4.
- `clear` coincident with an eop classification → all counters 0. Reset mid-frame → no counter changes and FSM is in IDLE.
